// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM encoding and instruction/word constants.
package cpu_pkg;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
    localparam logic [31:0] WORD_BYTES = 32'd4;

    typedef enum logic [1:0] {
        S_REQ,
        S_HOLD,
        S_DROP
    } fetch_state_t;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction memory req/ack bus between the fetch stage and instruction memory.
interface if_fetch_unit_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over imem req/ack, buffers a
// word fetched under stall, and drops the in-flight fetch on a redirect.
module if_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic                   redirect_valid,
    input  logic [31:0]            redirect_pc,
    if_fetch_unit_if.master        imem,
    output logic [31:0]            fetch_pc,
    output logic [31:0]            fetch_opcode,
    output logic                   ifid_flush
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  hold_q, hold_d;
    logic [31:0]  drop_addr_q, drop_addr_d;
    logic [31:0]  pc_plus4;
    logic [31:0]  redirect_target;

    assign pc_plus4        = pc_q + WORD_BYTES;
    assign redirect_target = redirect_pc & ~32'h0000_0003;

    // State, PC, hold buffer and abandoned-fetch address registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_PC;
            hold_q      <= '0;
            drop_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            hold_q      <= hold_d;
            drop_addr_q <= drop_addr_d;
        end
    end

    // Next-state, memory request and IF/ID delivery; redirect overrides everything.
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        hold_d         = hold_q;
        drop_addr_d    = drop_addr_q;
        imem.imem_req  = 1'b0;
        imem.imem_addr = (state_q == S_DROP) ? drop_addr_q : pc_q;
        fetch_pc       = '0;
        fetch_opcode   = NOP_INSTR;
        ifid_flush     = 1'b0;

        if (rst) begin
            imem.imem_req = (state_q == S_REQ) || (state_q == S_DROP);

            if (redirect_valid) begin
                ifid_flush = 1'b1;
                pc_d       = redirect_target;
                hold_d     = '0;
                // An unacked request in S_REQ keeps its address alive in S_DROP
                // until memory answers it.
                case (state_q)
                    S_REQ: begin
                        if (imem.imem_ack) begin
                            state_d = S_REQ;
                        end else begin
                            state_d     = S_DROP;
                            drop_addr_d = pc_q;
                        end
                    end
                    S_HOLD:  state_d = S_REQ;
                    S_DROP:  state_d = imem.imem_ack ? S_REQ : S_DROP;
                    default: state_d = S_REQ;
                endcase
            end else begin
                case (state_q)
                    S_REQ: begin
                        if (imem.imem_ack) begin
                            fetch_opcode = imem.imem_rdata;
                            fetch_pc     = pc_plus4;
                            if (stall) begin
                                hold_d  = imem.imem_rdata;
                                state_d = S_HOLD;
                            end else begin
                                pc_d = pc_plus4;
                            end
                        end
                    end
                    S_HOLD: begin
                        fetch_opcode = hold_q;
                        fetch_pc     = pc_plus4;
                        if (!stall) begin
                            pc_d    = pc_plus4;
                            state_d = S_REQ;
                        end
                    end
                    S_DROP: begin
                        if (imem.imem_ack) begin
                            state_d = S_REQ;
                        end
                    end
                    default: state_d = S_REQ;
                endcase
            end
        end
    end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage of the 5-stage pipeline. It owns the program counter and issues word reads to instruction memory over a req/ack handshake. It delivers each instruction, with its PC+4, to the IF/ID pipeline register. It honours the hazard unit's stall, and on a taken branch or jump it redirects the PC, discards in-flight fetches and drives the IF/ID flush.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset (word aligned)

Ports:
- clk  in  1  single clock; all state updates on posedge
- rst  in  1  asynchronous, active-low reset
- stall  in  1  hazard unit: IF/ID must not advance this cycle (inverse of IF/ID write enable)
- redirect_valid  in  1  taken branch/jump this cycle
- redirect_pc  in  32  branch/jump target
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch word address
- imem_ack  in  1  memory returns imem_rdata this cycle
- imem_rdata  in  32  instruction word
- fetch_pc  out  32  PC+4 of delivered instruction, to IF/ID PC input
- fetch_opcode  out  32  delivered instruction, 32'h0 (NOP) when none, to IF/ID opcode input
- ifid_flush  out  1  clear IF/ID (equals redirect_valid)

## Operation
- State: pc_q (32b), hold_q (32b buffer), FSM {S_REQ, S_HOLD, S_DROP}.
- Reset (rst=0): pc_q=RESET_PC, hold_q=0, state=S_REQ, imem_req=0. fetch_pc=0, fetch_opcode=0 and ifid_flush=0 for as long as rst is low.
- imem_req=1 in S_REQ and S_DROP whenever rst=1. imem_addr=pc_q, stable from request to ack. Same-cycle ack is allowed.
- S_REQ, ack, no stall: deliver imem_rdata and pc_q+4; pc_q<=pc_q+4; stay.
- S_REQ, ack, stall: hold_q<=imem_rdata; go to S_HOLD; pc_q unchanged.
- S_REQ, no ack: deliver the bubble (0/0); stay.
- S_HOLD: imem_req=0. Deliver hold_q and pc_q+4. When stall=0: pc_q<=pc_q+4 and go to S_REQ.
- S_DROP: the old request is still outstanding, with the address latched at the moment of redirect. Deliver the bubble. On ack, discard the data and go to S_REQ.
- Redirect (any state, highest priority, wins over stall):
  - pc_q<=redirect_pc with bits[1:0] forced to 0.
  - ifid_flush=1 and the bubble is delivered that cycle.
  - hold_q is invalidated.
  - Next state:
    - S_DROP if in S_REQ with no ack this cycle;
    - S_REQ if in S_REQ with ack;
    - S_REQ if in S_HOLD;
    - S_DROP if already in S_DROP with no ack;
    - S_REQ if in S_DROP with ack.
  - The old address is kept on imem_addr in S_DROP, via a separate drop_addr_q.
- Arithmetic: PC increment is modulo 2^32, so 32'hFFFF_FFFC+4 = 0.

## Timing
- fetch_* and ifid_flush are combinational from state and inputs; the IF/ID register provides the pipeline flop.
- Zero-wait memory (ack tied to req): one instruction per cycle. The instruction at RESET_PC is delivered in the first clock after rst rises.
- Redirect penalty, zero-wait memory: the target instruction is delivered in the cycle after redirect_valid.
- With N-cycle memory latency: a bubble on each cycle without ack; after a redirect mid-fetch, the old ack is consumed first, then the target fetch starts.
- Stall has no effect on memory handshake timing; an instruction fetched during stall waits in hold_q without re-fetch.
- Asynchronous reset mid-request abandons the request. Memory must tolerate imem_req dropping without ack.

## Structure
- Shared package cpu_pkg:
  - NOP_INSTR (32'h0);
  - fetch_state_t enum {S_REQ, S_HOLD, S_DROP};
  - WORD_BYTES (4).
- Single module; no sub-module. The PC, hold buffer and FSM are tightly coupled.

## Test plan
- Reset release, zero-wait memory, RESET_PC=0 -> imem_addr 0,4,8 on consecutive cycles; fetch_pc 4,8,12 with the matching rdata.
- Zero-wait memory, stall high 3 cycles at PC 0x10 -> fetch_opcode holds word@0x10 and fetch_pc=0x14 for 3 cycles; imem_req=0 in that window; after stall falls, the next imem_addr is 0x14.
- redirect_valid with redirect_pc=0x43 while sequential at 0x20 -> ifid_flush=1 with a 0/0 bubble; next cycle imem_addr=0x40 and fetch_pc=0x44.
- 3-cycle memory latency, redirect to 0x100 one cycle into a fetch at 0x8 -> imem_addr stays 0x8 until ack; the returned word is never delivered; the next request is 0x100.
- Stall and redirect in the same cycle while in S_HOLD -> redirect wins: flush=1, hold_q discarded, next fetch at the target.
- Boundary:
  - PC=0xFFFF_FFFC with ack -> fetch_pc=0 and the next imem_addr=0.
  - rst pulsed low mid-S_DROP -> imem_req=0 immediately; on release, fetch restarts at RESET_PC.
